// File: rtl/gcode_pkg.sv
// Shared types for the G-code command dispatcher: opcodes, command word, FSM encodings.
package gcode_pkg;

    localparam int CMD_W   = 5;
    localparam int COORD_W = 14;

    typedef enum logic [CMD_W-1:0] {
        CMD_G0   = 5'h00,
        CMD_G1   = 5'h01,
        CMD_G2   = 5'h02,
        CMD_G3   = 5'h03,
        CMD_G4   = 5'h04,
        CMD_G28  = 5'h05,
        CMD_HALT = 5'h1F
    } gcode_op_e;

    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } gcode_cmd_t;

    // Dispatcher states kept as fixed constants so the encoding never moves.
    typedef logic [2:0] disp_state_t;
    localparam disp_state_t ST_IDLE  = 3'd0;
    localparam disp_state_t ST_ISSUE = 3'd1;
    localparam disp_state_t ST_ACK   = 3'd2;
    localparam disp_state_t ST_RUN   = 3'd3;
    localparam disp_state_t ST_FAULT = 3'd4;

endpackage

// File: rtl/gcode_cmd_dispatcher_if.sv
// Interpreter-side push handshake and controller-side start/ready handshake.
interface gcode_cmd_dispatcher_if;
    import gcode_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [CMD_W-1:0]   in_cmd;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic               ctrl_ready;
    logic               ctrl_start;
    logic [CMD_W-1:0]   ctrl_cmd;
    logic [COORD_W-1:0] ctrl_x;
    logic [COORD_W-1:0] ctrl_y;

    modport master (
        output in_valid, in_cmd, in_x, in_y, ctrl_ready,
        input  in_ready, ctrl_start, ctrl_cmd, ctrl_x, ctrl_y
    );

    modport slave (
        input  in_valid, in_cmd, in_x, in_y, ctrl_ready,
        output in_ready, ctrl_start, ctrl_cmd, ctrl_x, ctrl_y
    );

endinterface

// File: rtl/gcode_cmd_fifo.sv
// Synchronous command FIFO with push, pop, flush and occupancy count.
module gcode_cmd_fifo
    import gcode_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  gcode_cmd_t                   din,
    output gcode_cmd_t                   dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    gcode_cmd_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    // Flush wins over everything queued or popped in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcode_cmd_dispatcher.sv
// Queues interpreter commands and issues them one at a time to the motion controller.
// Optional watchdog: define DISPATCH_WATCHDOG_EN.
module gcode_cmd_dispatcher
    import gcode_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    gcode_cmd_dispatcher_if.slave       bus,
    output logic                        busy,
    output logic [$clog2(DEPTH+1)-1:0]  queue_count,
    output logic                        fault,
    input  logic                        fault_clr
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    disp_state_t state, state_nxt;
    gcode_cmd_t  in_pkt, head, issued;
    logic        start_q;
    logic        fifo_full, fifo_empty;
    logic        accept, is_halt, push, pop, flush, wd_flush, issue_go;

    assign in_pkt   = '{cmd: bus.in_cmd, x: bus.in_x, y: bus.in_y};
    assign is_halt  = (bus.in_cmd == CMD_HALT);
    assign bus.in_ready = !fifo_full && (state != ST_FAULT);
    assign accept   = bus.in_valid && bus.in_ready;
    assign push     = accept && !is_halt;
    assign flush    = (accept && is_halt) || wd_flush;
    assign pop      = (state == ST_ISSUE);
    // A flush in the decision cycle must not launch the head it is discarding.
    assign issue_go = (state == ST_IDLE) && !fifo_empty && bus.ctrl_ready && !flush;

    gcode_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_pkt),
        .dout  (head),
        .count (queue_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef DISPATCH_WATCHDOG_EN
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;

    assign wd_hit   = ((state == ST_ACK) || (state == ST_RUN)) &&
                      (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign wd_flush = wd_hit || (state == ST_FAULT);
    assign fault    = (state == ST_FAULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   wd_cnt <= '0;
        else if (state == ST_ISSUE)                   wd_cnt <= '0;
        else if (state == ST_ACK || state == ST_RUN)  wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic [WD_W-1:0] unused_wd;
    logic            unused_clr;

    assign unused_wd  = WD_W'(TIMEOUT_CYCLES);
    assign unused_clr = fault_clr;
    assign wd_flush   = 1'b0;
    assign fault      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (issue_go) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_ACK;
            ST_ACK:   if (!bus.ctrl_ready) state_nxt = ST_RUN;
            ST_RUN:   if (bus.ctrl_ready) state_nxt = ST_IDLE;
`ifdef DISPATCH_WATCHDOG_EN
            ST_FAULT: if (fault_clr) state_nxt = ST_IDLE;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
`ifdef DISPATCH_WATCHDOG_EN
        if (wd_hit) state_nxt = ST_FAULT;
`endif
    end

    // Head is latched on the IDLE->ISSUE edge so outputs are valid alongside ctrl_start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            issued  <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= issue_go;
            if (issue_go) issued <= head;
        end
    end

    assign bus.ctrl_start = start_q;
    assign bus.ctrl_cmd   = issued.cmd;
    assign bus.ctrl_x     = issued.x;
    assign bus.ctrl_y     = issued.y;
    assign busy           = !fifo_empty || (state != ST_IDLE);

endmodule
